// File: rtl/carrier_nco_pkg.sv
// Shared definitions for the NCO carrier generator: default geometry and
// quadrant encoding of the phase word's two MSBs.
package carrier_nco_pkg;

  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned LUT_AW_DEF  = 6;
  localparam int unsigned AMP_W_DEF   = 16;

  typedef enum logic [1:0] {
    Q_I   = 2'd0,
    Q_II  = 2'd1,
    Q_III = 2'd2,
    Q_IV  = 2'd3
  } quad_e;

endpackage

// File: rtl/carrier_nco_rom.sv
// Quarter-wave sine magnitude ROM: entry k = round(32767*sin(pi*k/128)),
// k = 0..64, i.e. the 15-bit / 65-entry geometry of the default carrier.
module carrier_nco_rom #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 65
) (
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  output logic [WIDTH-1:0]         data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam int unsigned TABLE [65] = '{
        0,   804,  1608,  2410,  3212,  4011,  4808,  5602,
     6393,  7179,  7962,  8739,  9512, 10278, 11039, 11793,
    12539, 13279, 14010, 14732, 15446, 16151, 16846, 17530,
    18204, 18868, 19519, 20159, 20787, 21403, 22005, 22594,
    23170, 23731, 24279, 24811, 25329, 25832, 26319, 26790,
    27245, 27683, 28105, 28510, 28898, 29268, 29621, 29956,
    30273, 30571, 30852, 31113, 31356, 31580, 31785, 31971,
    32137, 32285, 32412, 32521, 32609, 32678, 32728, 32757,
    32767
  };

  always_comb begin
    data_o = '0;
    if (addr_i <= AW'(DEPTH - 1)) begin
      data_o = WIDTH'(TABLE[addr_i]);
    end
  end

endmodule

// File: rtl/carrier_nco.sv
// Phase-accumulator carrier NCO with static offset and BPSK half-turn flip;
// two-stage pipeline (address/quadrant, then signed ROM sample).
module carrier_nco
  import carrier_nco_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned LUT_AW  = LUT_AW_DEF,
  parameter int unsigned AMP_W   = AMP_W_DEF
) (
  input  logic                    clk_sig,
  input  logic                    rst_n,
  input  logic                    en_sig,
  input  logic                    ftw_load_sig,
  input  logic [PHASE_W-1:0]      ftw_sig,
  input  logic [PHASE_W-1:0]      phase_off_sig,
  input  logic                    bpsk_sig,
  input  logic                    sync_clr_sig,
  output logic signed [AMP_W-1:0] carrier_sig,
  output logic [1:0]              quad_sig,
  output logic                    valid_sig,
  output logic                    wrap_sig
);

  localparam int unsigned ROM_AW    = LUT_AW + 1;
  localparam int unsigned ROM_DEPTH = (1 << LUT_AW) + 1;
  localparam logic [ROM_AW-1:0] QTR = ROM_AW'(1 << LUT_AW);

  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] phase;
  logic [LUT_AW-1:0]  idx;
  quad_e              quad_p;
  logic               unused_phase;

  logic [ROM_AW-1:0]  addr_a_q, addr_a_d;
  quad_e              quad_a_q;
  logic               valid_a_q;

  logic [AMP_W-2:0]   mag;
  logic [AMP_W-1:0]   mag_ext;
  logic [AMP_W-1:0]   carrier_q, carrier_d;
  quad_e              quad_q;
  logic               valid_q;

  assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
  assign ftw_d   = ftw_load_sig ? ftw_sig : ftw_q;

  always_comb begin
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (sync_clr_sig) begin
      acc_d = '0;
    end else if (en_sig) begin
      acc_d  = acc_sum[PHASE_W-1:0];
      wrap_d = acc_sum[PHASE_W];
    end
  end

  // Lookup uses the pre-update accumulator; truncated LSBs are discarded.
  assign phase        = acc_q + phase_off_sig + {bpsk_sig, {(PHASE_W-1){1'b0}}};
  assign quad_p       = quad_e'(phase[PHASE_W-1 -: 2]);
  assign idx          = phase[PHASE_W-3 -: LUT_AW];
  assign unused_phase = ^phase;

  always_comb begin
    addr_a_d = {1'b0, idx};
    case (quad_p)
      Q_II, Q_IV: addr_a_d = QTR - {1'b0, idx};
      default:    addr_a_d = {1'b0, idx};
    endcase
  end

  carrier_nco_rom #(
    .WIDTH (AMP_W - 1),
    .DEPTH (ROM_DEPTH)
  ) u_rom (
    .addr_i (addr_a_q),
    .data_o (mag)
  );

  assign mag_ext = {1'b0, mag};

  always_comb begin
    carrier_d = mag_ext;
    if (quad_a_q == Q_III || quad_a_q == Q_IV) begin
      carrier_d = -mag_ext;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      ftw_q     <= '0;
      acc_q     <= '0;
      wrap_q    <= 1'b0;
      addr_a_q  <= '0;
      quad_a_q  <= Q_I;
      valid_a_q <= 1'b0;
      carrier_q <= '0;
      quad_q    <= Q_I;
      valid_q   <= 1'b0;
    end else begin
      ftw_q     <= ftw_d;
      acc_q     <= acc_d;
      wrap_q    <= wrap_d;
      addr_a_q  <= addr_a_d;
      quad_a_q  <= quad_p;
      valid_a_q <= en_sig;
      carrier_q <= carrier_d;
      quad_q    <= quad_a_q;
      valid_q   <= valid_a_q;
    end
  end

  assign carrier_sig = carrier_q;
  assign quad_sig    = quad_q;
  assign valid_sig   = valid_q;
  assign wrap_sig    = wrap_q;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed bench for carrier_nco: sweep against a real-valued sine model plus
// hand-computed checks of offset, BPSK, tuning, hold, clear and reset timing.
module tb_carrier_nco;

  logic               clk_sig = 1'b0;
  logic               rst_n;
  logic               en_sig;
  logic               ftw_load_sig;
  logic [15:0]        ftw_sig;
  logic [15:0]        phase_off_sig;
  logic               bpsk_sig;
  logic               sync_clr_sig;
  logic signed [15:0] carrier_sig;
  logic [1:0]         quad_sig;
  logic               valid_sig;
  logic               wrap_sig;

  int checks   = 0;
  int failures = 0;

  carrier_nco #(
    .PHASE_W (16),
    .LUT_AW  (6),
    .AMP_W   (16)
  ) dut (
    .clk_sig       (clk_sig),
    .rst_n         (rst_n),
    .en_sig        (en_sig),
    .ftw_load_sig  (ftw_load_sig),
    .ftw_sig       (ftw_sig),
    .phase_off_sig (phase_off_sig),
    .bpsk_sig      (bpsk_sig),
    .sync_clr_sig  (sync_clr_sig),
    .carrier_sig   (carrier_sig),
    .quad_sig      (quad_sig),
    .valid_sig     (valid_sig),
    .wrap_sig      (wrap_sig)
  );

  always #5 clk_sig = ~clk_sig;

  task automatic tick;
    @(posedge clk_sig);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Full-wave golden sample from the 8 retained phase bits.
  function automatic int golden(input int unsigned p);
    int unsigned pt;
    real m;
    pt = (p >> 8) & 32'd255;
    m  = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(pt) / 256.0);
    if (m >= 0.0) return $rtoi(m + 0.5);
    return -$rtoi(-m + 0.5);
  endfunction

  initial begin
    rst_n         = 1'b0;
    en_sig        = 1'b0;
    ftw_load_sig  = 1'b0;
    ftw_sig       = '0;
    phase_off_sig = '0;
    bpsk_sig      = 1'b0;
    sync_clr_sig  = 1'b0;
    tick;
    tick;
    check("rst_carrier", carrier_sig, 0);
    check("rst_quad",    quad_sig,    0);
    check("rst_valid",   valid_sig,   0);
    check("rst_wrap",    wrap_sig,    0);

    rst_n        = 1'b1;
    ftw_load_sig = 1'b1;
    ftw_sig      = 16'h0100;
    tick;
    ftw_load_sig = 1'b0;
    en_sig       = 1'b1;

    // After tick m, outputs show acc = (m-2)*0x100.
    for (int m = 1; m <= 512; m++) begin
      int unsigned ph;
      tick;
      check("sweep_wrap", wrap_sig, (m % 256 == 0) ? 1 : 0);
      if (m == 1) begin
        check("first_valid_low", valid_sig, 0);
      end else begin
        ph = 32'((m - 2) * 256) & 32'hFFFF;
        check("sweep_carrier", carrier_sig, golden(ph));
        check("sweep_quad",    quad_sig,    (ph >> 14) & 3);
        check("sweep_valid",   valid_sig,   1);
        if (m == 66)  check("peak_pos_4000", carrier_sig, 32767);
        if (m == 130) check("zero_8000",     carrier_sig, 0);
        if (m == 194) check("peak_neg_C000", carrier_sig, -32767);
      end
    end

    en_sig        = 1'b0;
    phase_off_sig = 16'h4000;
    tick;
    tick;
    check("off_carrier", carrier_sig, 32767);
    check("off_quad",    quad_sig,    1);
    check("off_valid",   valid_sig,   0);
    check("off_wrap",    wrap_sig,    0);

    bpsk_sig = 1'b1;
    tick;
    check("bpsk_1cyc", carrier_sig, 32767);
    tick;
    check("bpsk_2cyc", carrier_sig, -32767);
    check("bpsk_quad", quad_sig,    3);

    bpsk_sig      = 1'b0;
    phase_off_sig = '0;
    en_sig        = 1'b1;
    ftw_load_sig  = 1'b1;
    ftw_sig       = 16'h0200;
    tick;
    ftw_load_sig = 1'b0;
    tick;
    check("ld_p0000",  carrier_sig, 0);
    check("ld_valid",  valid_sig,   1);
    tick;
    check("ld_p0100",  carrier_sig, 804);
    tick;
    check("ld_p0300",  carrier_sig, 2410);
    tick;
    check("ld_p0500",  carrier_sig, 4011);

    en_sig = 1'b0;
    tick;
    check("hold_last_valid", carrier_sig, 5602);
    check("hold_valid_1",    valid_sig,   1);
    tick;
    check("hold_p0900",  carrier_sig, 7179);
    check("hold_valid_0", valid_sig,  0);
    tick;
    tick;
    tick;
    check("hold_5_car",   carrier_sig, 7179);
    check("hold_5_valid", valid_sig,   0);
    en_sig = 1'b1;
    tick;
    check("resume_valid_0", valid_sig, 0);
    tick;
    check("resume_car",     carrier_sig, 7179);
    check("resume_valid_1", valid_sig,   1);
    tick;
    check("resume_p0B00",   carrier_sig, 8739);

    en_sig       = 1'b0;
    sync_clr_sig = 1'b1;
    ftw_load_sig = 1'b1;
    ftw_sig      = 16'h3F00;
    tick;
    sync_clr_sig = 1'b0;
    en_sig       = 1'b1;
    ftw_sig      = 16'hC200;
    tick;
    ftw_load_sig = 1'b0;
    sync_clr_sig = 1'b1;
    tick;
    check("clr_no_wrap", wrap_sig, 0);
    sync_clr_sig = 1'b0;
    tick;
    check("clr_pre_p3F00", carrier_sig, 32757);
    check("clr_wrap_low",  wrap_sig,    0);
    tick;
    check("clr_out_zero",  carrier_sig, 0);
    check("clr_out_valid", valid_sig,   1);
    check("clr_then_wrap", wrap_sig,    1);

    rst_n = 1'b0;
    tick;
    check("mrst_carrier", carrier_sig, 0);
    check("mrst_quad",    quad_sig,    0);
    check("mrst_valid",   valid_sig,   0);
    check("mrst_wrap",    wrap_sig,    0);
    rst_n = 1'b1;
    tick;
    check("mrst_valid_1cyc", valid_sig, 0);
    tick;
    check("mrst_valid_2cyc", valid_sig,   1);
    check("mrst_car_2cyc",   carrier_sig, 0);
    tick;
    tick;
    check("mrst_acc_stuck",  carrier_sig, 0);
    check("mrst_quad_stuck", quad_sig,    0);
    check("mrst_no_wrap",    wrap_sig,    0);

    ftw_load_sig = 1'b1;
    ftw_sig      = 16'h4000;
    tick;
    ftw_load_sig = 1'b0;
    tick;
    tick;
    check("reload_p0000", carrier_sig, 0);
    tick;
    check("reload_p4000", carrier_sig, 32767);
    check("reload_quad",  quad_sig,    1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carrier_nco.md
# carrier_nco

Parametrised numerically-controlled carrier generator for the BPSK transmit path. It replaces the fixed 64-step quarter-wave carrier with three additions: a phase accumulator with a programmable frequency tuning word, a static phase offset, and an in-phase BPSK 180° flip. It sits between the symbol/bit source and the DAC/modulator output. It produces a signed sine sample every cycle from a quarter-wave ROM using quadrant symmetry.

## Interface
- PHASE_W, 16: phase accumulator width; must satisfy PHASE_W >= LUT_AW+2
- LUT_AW, 6: quarter-wave index bits; ROM depth 2^LUT_AW+1
- AMP_W, 16: signed output width; ROM word width AMP_W-1
- clk_sig  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en_sig  in  1  advance accumulator; tags output sample valid
- ftw_load_sig  in  1  latch ftw_sig into tuning register
- ftw_sig  in  PHASE_W  frequency tuning word (unsigned phase step)
- phase_off_sig  in  PHASE_W  static phase offset added before lookup
- bpsk_sig  in  1  data bit; 1 adds half turn (2^(PHASE_W-1))
- sync_clr_sig  in  1  clear accumulator to 0 (phase realign)
- carrier_sig  out  AMP_W  signed two's-complement sine sample
- quad_sig  out  2  quadrant of the emitted sample
- valid_sig  out  1  carrier_sig corresponds to an enabled phase step
- wrap_sig  out  1  one-cycle pulse: accumulator overflowed

## Operation
- Tuning register ftw_q: loads ftw_sig when ftw_load_sig=1.
- Accumulator acc: updates as acc <= acc + ftw_q (mod 2^PHASE_W) when en_sig=1; holds otherwise. Carry-out is registered into wrap_sig.
- Phase word p = acc + phase_off_sig + (bpsk_sig << (PHASE_W-1)), mod 2^PHASE_W. It uses the pre-update acc value.
- Quadrant q = p[PHASE_W-1:PHASE_W-2]. Index i = p[PHASE_W-3:PHASE_W-2-LUT_AW]; lower bits are truncated with no dithering.
- ROM address (LUT_AW+1 bits): q=0 or 2 gives i; q=1 or 3 gives 2^LUT_AW - i.
- Sign: q=0,1 emits +mag; q=2,3 emits -mag (two's complement of zero-extended magnitude).
- ROM entry k = round((2^(AMP_W-1)-1)·sin(πk/2^(LUT_AW+1))), k = 0..2^LUT_AW.
  - Entry 0 = 0; the last entry = full scale.
  - Negation can never overflow.
- Priority, highest first:
  - rst_n=0: ftw_q, acc, pipeline regs and all outputs go to 0.
  - sync_clr_sig=1: acc <= 0, wrap_sig <= 0, regardless of en_sig.
  - en_sig accumulate.
- Simultaneous ftw_load_sig and en_sig: this cycle's accumulate uses the old ftw_q; the new word takes effect next cycle.
- BPSK flip does not disturb acc; the carrier stays phase-continuous apart from the 180° jump.

## Timing
- Stage A (edge t): registers ROM address, quadrant and valid_a <= en_sig from p, sampled at edge t.
- Stage B (edge t+1): carrier_sig, quad_sig, valid_sig from ROM(addr_a) and quad_a.
- Latency: inputs sampled at edge t (acc, phase_off_sig, bpsk_sig, en_sig) appear on outputs after edge t+1, i.e. 2 cycles.
- Pipeline always flows. With en_sig=0, outputs keep repeating the held phase sample with valid_sig=0.
- wrap_sig: asserted in the cycle following the edge where acc wrapped.
- Reset mid-operation: outputs read 0 the cycle after the reset edge. After release, the first valid_sig comes 2 cycles after the first en_sig.

## Structure
- Shared package/header holds:
  - Quadrant localparams Q_I=0, Q_II=1, Q_III=2, Q_IV=3.
  - Default PHASE_W/LUT_AW/AMP_W.
- Sub-module: existing rom, instantiated with WIDTH=AMP_W-1, DEPTH=2^LUT_AW+1.
- The accumulator is inline; no separate counter instance.

## Test plan
- Defaults, ftw=0x0100, en=1, off=0, bpsk=0:
  - carrier follows 256-sample period.
  - Sample at acc=0x4000 gives 32767; at acc=0xC000 gives -32767; at acc=0x8000 gives 0.
  - wrap_sig pulses every 256 enabled cycles.
- phase_off=0x4000, acc=0: output 32767; bpsk=1 at acc=0x4000 gives -32767, appearing exactly 2 cycles after bpsk_sig changes.
- ftw_load with ftw=0x0200 while running:
  - next step still +0x0100, then +0x0200.
  - en_sig=0 for 5 cycles holds acc and drops valid_sig after 2 cycles.
- sync_clr_sig together with en_sig at acc=0x3F00: acc=0 next cycle; output 0 two cycles later; no wrap_sig.
- rst_n=0 for one cycle mid-stream:
  - all outputs 0 next cycle; ftw_q=0, so acc stays 0 until reloaded.
- Exhaustive sweep with ftw=0x0100: every sample equals the golden sin model to ±0 LSB; symmetry holds across all four quadrants.
